psa_mem_loader: RTL and testbench
=================================

Name: psa_mem_loader

Overview:
- Writer side of the PSA block memories: accepts a byte stream over a valid/ready handshake and writes it into the data BRAM or pattern BRAM.
- Writes start at a base address, for a programmed length.
- An optional read-back pass recomputes an 8-bit additive checksum and flags corruption.
- Sits between the host byte source and the BRAM port A, ahead of the search engine, which only reads.

Parameters:
- ADDR_W, 15, BRAM address width; all address arithmetic is modulo 2^ADDR_W.
- DATA_W, 8, byte width of stream and BRAM data.
- RD_LAT, 2, BRAM read latency in cycles from mem_addr registered to mem_dout valid.

Ports:
- CLK100MHZ  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high; returns block to IDLE.
- start  input  1  single-cycle request; latches base, len, verify_en in IDLE or DONE.
- base  input  ADDR_W  first BRAM address to write.
- len  input  ADDR_W  number of bytes to write; 0 is a legal empty job.
- verify_en  input  1  when 1, run the read-back checksum pass after the load.
- s_valid  input  1  stream byte valid.
- s_data  input  DATA_W  stream byte.
- s_ready  output  1  loader accepts a byte this cycle.
- mem_en  output  1  BRAM enable.
- mem_we  output  1  BRAM write enable.
- mem_addr  output  ADDR_W  BRAM address.
- mem_din  output  DATA_W  BRAM write data.
- mem_dout  input  DATA_W  BRAM read data.
- busy  output  1  high in LOAD and VERIFY.
- done  output  1  high while in DONE.
- error  output  1  checksum mismatch in the last verify; valid while done=1.
- count  output  ADDR_W  bytes accepted in the current or last job.
- checksum  output  DATA_W  running sum of accepted bytes, mod 256.

Behaviour:
- Reset values: s_ready=0, mem_en=0, mem_we=0, mem_addr=0, mem_din=0, busy=0, done=0, error=0, count=0, checksum=0, state=IDLE.
- Reset mid-job aborts with no further writes; mem_we is 0 from the first edge with reset high.
- All outputs are registered except s_ready, which is decoded from state (s_ready = state==LOAD).
- The states are IDLE, LOAD, VERIFY and DONE.
- IDLE / DONE, on start:
  - latch base, len and verify_en;
  - clear count, checksum and error;
  - drop done;
  - if len==0, go to DONE on the next edge (done=1 one cycle after start, no BRAM access);
  - otherwise go to LOAD.
- IDLE / DONE, without start: start is ignored while busy.
- LOAD:
  - A handshake is s_valid && s_ready.
  - On a handshake at edge n: at n+1, mem_en=1, mem_we=1, mem_addr=(base+count) mod 2^ADDR_W, mem_din=s_data; count increments and checksum += s_data.
  - With no handshake: mem_we=0 and mem_en=0.
  - On the handshake that makes count==len: go to VERIFY if verify_en, else DONE.
  - No bubble is required; back-to-back bytes are accepted every cycle.
- VERIFY:
  - Read index r runs 0..len-1, one per cycle: mem_en=1, mem_we=0, mem_addr=(base+r) mod 2^ADDR_W.
  - A valid shift register of depth RD_LAT tags returning data; each tagged mem_dout is added to a local sum (mod 256).
  - When the last tagged byte returns: error = (sum != checksum); go to DONE.
  - Total VERIFY duration is len+RD_LAT cycles.
  - s_ready=0 throughout.
- DONE:
  - done=1, busy=0, mem_en=0.
  - count, checksum and error are held until the next start.
- Address wrap: base+len beyond 2^ADDR_W-1 wraps to 0; this is not an error.
- start held during LOAD or VERIFY has no effect, and the latched values do not change.
- s_valid with state!=LOAD: the byte is not consumed (s_ready=0).

Test Plan:
1. reset; start base=0x0010 len=4 verify_en=0; stream 0x41,0x42,0x43,0x44 back-to-back -> four writes at 0x0010..0x0013 on consecutive cycles, count=4, checksum=0x0A, done=1 one cycle after the last write, error=0.
2. Same job with verify_en=1 and a BRAM model of RD_LAT=2 -> 4 reads at 0x0010..0x0013, done 6 cycles after entering VERIFY, error=0; rerun with the model corrupting 0x0012 to 0x00 -> error=1.
3. base=0x7FFE len=3 -> writes to 0x7FFE, 0x7FFF, 0x0000; count=3.
4. len=0 start -> done=1 next cycle, no mem_en pulse, count=0, checksum=0.
5. s_valid toggled 1,0,1,1,0,1 with len=4 -> exactly 4 writes, addresses contiguous, no write on idle cycles; start pulsed mid-LOAD is ignored.
6. reset asserted after 2 of 8 bytes -> mem_we=0 from the next edge, s_ready=0, busy=0, count=0; a subsequent job completes normally.

Source files
------------

// File: rtl/psa_mem_loader_if.sv
// Byte-stream handshake and BRAM port A bundle between the host source, the loader and the memory.
interface psa_mem_loader_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) ();
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport master (
    input  s_valid, s_data, mem_dout,
    output s_ready, mem_en, mem_we, mem_addr, mem_din
  );

  modport slave (
    output s_valid, s_data, mem_dout,
    input  s_ready, mem_en, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/psa_mem_loader.sv
// Writes a byte stream into PSA block memory from a base address, with an optional
// read-back pass that recomputes the additive checksum and flags corruption.
//
// state     | meaning
// ST_IDLE   | waiting for start after reset
// ST_LOAD   | accepting stream bytes, one BRAM write per handshake
// ST_VERIFY | reading the job back and summing returned bytes
// ST_DONE   | job finished; count/checksum/error held until next start
module psa_mem_loader #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  input  logic              verify_en,
  psa_mem_loader_if.master  bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] count,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_VERIFY = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] len_q;
  logic              verify_q;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] ret_cnt;
  logic [DATA_W-1:0] vsum;
  logic [RD_LAT-1:0] vld;
  logic              hs;
  logic              rd_issue;
  logic              rd_ret;

  assign bus.s_ready = (state == ST_LOAD);
  assign hs          = bus.s_valid && bus.s_ready;
  assign rd_issue    = (state == ST_VERIFY) && (rd_idx != len_q);
  // vld[0] rises with the read address; the top tap lines up with mem_dout
  assign rd_ret      = (state == ST_VERIFY) && vld[RD_LAT-1];

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state        <= ST_IDLE;
      base_q       <= '0;
      len_q        <= '0;
      verify_q     <= 1'b0;
      rd_idx       <= '0;
      ret_cnt      <= '0;
      vsum         <= '0;
      vld          <= '0;
      bus.mem_en   <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      count        <= '0;
      checksum     <= '0;
    end else begin
      bus.mem_en <= 1'b0;
      bus.mem_we <= 1'b0;
      vld        <= (vld << 1) | RD_LAT'(rd_issue);

      case (state)
        ST_IDLE, ST_DONE: begin
          if (state == ST_DONE) done <= 1'b1;
          if (start) begin
            base_q   <= base;
            len_q    <= len;
            verify_q <= verify_en;
            count    <= '0;
            checksum <= '0;
            error    <= 1'b0;
            if (len == '0) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              done  <= 1'b0;
              busy  <= 1'b1;
              state <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          if (hs) begin
            bus.mem_en   <= 1'b1;
            bus.mem_we   <= 1'b1;
            bus.mem_addr <= base_q + count;
            bus.mem_din  <= bus.s_data;
            count        <= count + ONE_A;
            checksum     <= checksum + bus.s_data;
            if ((count + ONE_A) == len_q) begin
              if (verify_q) begin
                rd_idx  <= '0;
                ret_cnt <= '0;
                vsum    <= '0;
                state   <= ST_VERIFY;
              end else begin
                busy  <= 1'b0;
                state <= ST_DONE;
              end
            end
          end
        end

        ST_VERIFY: begin
          if (rd_issue) begin
            bus.mem_en   <= 1'b1;
            bus.mem_addr <= base_q + rd_idx;
            rd_idx       <= rd_idx + ONE_A;
          end
          if (rd_ret) begin
            vsum    <= vsum + bus.mem_dout;
            ret_cnt <= ret_cnt + ONE_A;
            if (ret_cnt == (len_q - ONE_A)) begin
              error <= ((vsum + bus.mem_dout) != checksum);
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_DONE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psa_mem_loader.sv
// Directed bench for psa_mem_loader: write/read scoreboards fed by a simple BRAM model.
module tb_psa_mem_loader;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;

  logic              CLK100MHZ = 1'b0;
  logic              reset     = 1'b1;
  logic              start     = 1'b0;
  logic              verify_en = 1'b0;
  logic [ADDR_W-1:0] base      = '0;
  logic [ADDR_W-1:0] len       = '0;
  logic              busy, done, error;
  logic [ADDR_W-1:0] count;
  logic [DATA_W-1:0] checksum;

  int tests = 0;
  int fails = 0;

  psa_mem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  psa_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .start     (start),
    .base      (base),
    .len       (len),
    .verify_en (verify_en),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .count     (count),
    .checksum  (checksum)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  // BRAM model: one output register, so data is sampled RD_LAT edges after the address
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  logic       corrupt = 1'b0;
  logic [7:0] rd_q    = 8'h00;
  always @(posedge CLK100MHZ) begin
    if (bus.mem_en) begin
      if (bus.mem_we)
        mem[bus.mem_addr] <= (corrupt && bus.mem_addr == 15'h0012) ? 8'h00 : bus.mem_din;
      else
        rd_q <= mem[bus.mem_addr];
    end
  end
  assign bus.mem_dout = rd_q;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;
  wr_t               wq[$];
  logic [ADDR_W-1:0] rq[$];
  int n_wr = 0;
  int n_rd = 0;
  int n_en = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK100MHZ) begin
    if (bus.mem_en) n_en++;
    if (bus.mem_en && bus.mem_we) begin
      n_wr++;
      if (wq.size() == 0) begin
        chk("wr_unexpected", {17'd0, bus.mem_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr", {17'd0, bus.mem_addr}, {17'd0, e.addr});
        chk("wr_data", {24'd0, bus.mem_din}, {24'd0, e.data});
      end
    end
    if (bus.mem_en && !bus.mem_we) begin
      n_rd++;
      if (rq.size() == 0) begin
        chk("rd_unexpected", {17'd0, bus.mem_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [ADDR_W-1:0] ea;
        ea = rq.pop_front();
        chk("rd_addr", {17'd0, bus.mem_addr}, {17'd0, ea});
      end
    end
  end

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic start_job(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l, input logic v);
    base = b; len = l; verify_en = v; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic [ADDR_W-1:0] a);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    while (!bus.s_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.s_ready) chk("s_ready_timeout", 32'd0, 32'd1);
    else              wq.push_back('{addr: a, data: b});
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk("done_wait", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, rd0, en0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;

    // reset state
    tick(); tick(); tick();
    chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
    chk("rst_mem_en",  {31'd0, bus.mem_en},  32'd0);
    chk("rst_mem_we",  {31'd0, bus.mem_we},  32'd0);
    chk("rst_addr",    {17'd0, bus.mem_addr}, 32'd0);
    chk("rst_busy",    {31'd0, busy},  32'd0);
    chk("rst_done",    {31'd0, done},  32'd0);
    chk("rst_count",   {17'd0, count}, 32'd0);
    chk("rst_csum",    {24'd0, checksum}, 32'd0);
    reset = 1'b0;
    tick();

    // 1: plain load, back-to-back
    wr0 = n_wr;
    start_job(15'h0010, 15'd4, 1'b0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    send(8'h41, 15'h0010);
    send(8'h42, 15'h0011);
    send(8'h43, 15'h0012);
    send(8'h44, 15'h0013);
    chk("t1_last_we",   {31'd0, bus.mem_we}, 32'd1);
    chk("t1_done_early", {31'd0, done}, 32'd0);
    tick();
    chk("t1_done",  {31'd0, done}, 32'd1);
    chk("t1_we_off", {31'd0, bus.mem_we}, 32'd0);
    chk("t1_count", {17'd0, count}, 32'd4);
    chk("t1_csum",  {24'd0, checksum}, 32'h0A);
    chk("t1_error", {31'd0, error}, 32'd0);
    chk("t1_busy_off", {31'd0, busy}, 32'd0);
    chk("t1_nwr",   n_wr - wr0, 32'd4);

    // 2: load + verify, clean then corrupted
    for (int pass = 0; pass < 2; pass++) begin
      corrupt = (pass == 1);
      rd0 = n_rd;
      start_job(15'h0010, 15'd4, 1'b1);
      for (int i = 0; i < 4; i++) rq.push_back(15'h0010 + 15'(i));
      send(8'h41, 15'h0010);
      send(8'h42, 15'h0011);
      send(8'h43, 15'h0012);
      send(8'h44, 15'h0013);
      chk("t2_busy_verify", {31'd0, busy}, 32'd1);
      chk("t2_s_ready", {31'd0, bus.s_ready}, 32'd0);
      for (int i = 0; i < 5; i++) tick();
      chk("t2_done_early", {31'd0, done}, 32'd0);
      tick();
      chk("t2_done",  {31'd0, done}, 32'd1);
      chk("t2_error", {31'd0, error}, (pass == 1) ? 32'd1 : 32'd0);
      chk("t2_csum",  {24'd0, checksum}, 32'h0A);
      chk("t2_nrd",   n_rd - rd0, 32'd4);
    end
    corrupt = 1'b0;

    // 3: address wrap
    start_job(15'h7FFE, 15'd3, 1'b0);
    send(8'h11, 15'h7FFE);
    send(8'h22, 15'h7FFF);
    send(8'h33, 15'h0000);
    wait_done(5);
    chk("t3_count", {17'd0, count}, 32'd3);
    chk("t3_csum",  {24'd0, checksum}, 32'h66);

    // 4: empty job
    en0 = n_en;
    start_job(15'h0123, 15'd0, 1'b1);
    chk("t4_done",  {31'd0, done}, 32'd1);
    chk("t4_busy",  {31'd0, busy}, 32'd0);
    chk("t4_count", {17'd0, count}, 32'd0);
    chk("t4_csum",  {24'd0, checksum}, 32'd0);
    tick(); tick(); tick();
    chk("t4_no_en", n_en - en0, 32'd0);

    // 5: gapped stream with a stray start during LOAD
    wr0 = n_wr;
    start_job(15'h0200, 15'd4, 1'b0);
    send(8'h10, 15'h0200);
    base = 15'h5555; len = 15'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_busy_after_start", {31'd0, busy}, 32'd1);
    send(8'h20, 15'h0201);
    send(8'h30, 15'h0202);
    tick();
    send(8'h40, 15'h0203);
    wait_done(5);
    chk("t5_count", {17'd0, count}, 32'd4);
    chk("t5_csum",  {24'd0, checksum}, 32'hA0);
    chk("t5_nwr",   n_wr - wr0, 32'd4);

    // 6: reset mid-job, then a clean verified job
    start_job(15'h0300, 15'd8, 1'b0);
    send(8'h01, 15'h0300);
    send(8'h02, 15'h0301);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h03;
    reset = 1'b1;
    tick();
    chk("t6_we",      {31'd0, bus.mem_we}, 32'd0);
    chk("t6_s_ready", {31'd0, bus.s_ready}, 32'd0);
    chk("t6_busy",    {31'd0, busy}, 32'd0);
    chk("t6_count",   {17'd0, count}, 32'd0);
    chk("t6_csum",    {24'd0, checksum}, 32'd0);
    reset = 1'b0;
    bus.s_valid = 1'b0;
    tick();
    start_job(15'h0400, 15'd2, 1'b1);
    rq.push_back(15'h0400);
    rq.push_back(15'h0401);
    send(8'h5A, 15'h0400);
    send(8'hA5, 15'h0401);
    wait_done(10);
    chk("t6_count2", {17'd0, count}, 32'd2);
    chk("t6_csum2",  {24'd0, checksum}, 32'hFF);
    chk("t6_error2", {31'd0, error}, 32'd0);

    tick();
    chk("wq_empty", wq.size(), 32'd0);
    chk("rq_empty", rq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
